// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//   Writer-side front end for the 8x16 register file. Results from the
//   execution units are queued in order as (index, data) pairs and drained
//   to the register-file write port at most once per cycle. Operand fetch
//   can look up its A and B read indices against the queued entries, so a
//   read sees results that have not been written yet.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   in_valid/in_ready          producer handshake; in_ready = !full
//   in_index, in_data          incoming writeback
//   drain_stall                write port busy, hold the head entry
//   rf_we/rf_c_index/rf_d_input  register-file write port
//   a_index/b_index            lookup indices from operand fetch
//   a_hit/a_fwd_data           newest queued data for a_index (0 on miss)
//   b_hit/b_fwd_data           same for b_index
//   count/empty/full           occupancy, from the registered count
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IDX_W-1:0]           in_index,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       drain_stall,
  output logic                       rf_we,
  output logic [IDX_W-1:0]           rf_c_index,
  output logic [DATA_W-1:0]          rf_d_input,
  input  logic [IDX_W-1:0]           a_index,
  input  logic [IDX_W-1:0]           b_index,
  output logic                       a_hit,
  output logic [DATA_W-1:0]          a_fwd_data,
  output logic                       b_hit,
  output logic [DATA_W-1:0]          b_fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  cnt;
  logic              push, pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign count    = cnt;
  // No same-cycle pass-through: a full queue refuses even while popping.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign rf_we    = !empty && !drain_stall;
  assign pop      = rf_we;

  assign rf_c_index = empty ? '0 : idx_mem[head];
  assign rf_d_input = empty ? '0 : data_mem[head];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: entry storage has no reset; validity comes from head/count alone,
  // so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail]  <= in_index;
      data_mem[tail] <= in_data;
    end
  end

  // Forwarding scan from oldest to youngest; a later match overwrites an
  // earlier one so the entry closest to tail wins. The head entry counts
  // even while it is being written, since the register file updates only
  // at the edge. The entry being pushed this cycle is not yet occupied.
  always_comb begin
    logic [PTR_W-1:0] pos;
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    a_hit      = 1'b0;
    a_fwd_data = '0;
    b_hit      = 1'b0;
    b_fwd_data = '0;
    pos        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head + i[PTR_W-1:0];
      if (CNT_W'(i) < cnt) begin
        if (idx_mem[pos] == a_index) begin
          a_hit      = 1'b1;
          a_fwd_data = data_mem[pos];
        end
        if (idx_mem[pos] == b_index) begin
          b_hit      = 1'b1;
          b_fwd_data = data_mem[pos];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IDX_W-1:0]  in_index = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_stall = 1'b0;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_c_index;
  logic [DATA_W-1:0] rf_d_input;
  logic [IDX_W-1:0]  a_index = '0;
  logic [IDX_W-1:0]  b_index = '0;
  logic              a_hit, b_hit;
  logic [DATA_W-1:0] a_fwd_data, b_fwd_data;
  logic [2:0]        count;
  logic              empty, full;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_data(in_data),
    .drain_stall(drain_stall),
    .rf_we(rf_we), .rf_c_index(rf_c_index), .rf_d_input(rf_d_input),
    .a_index(a_index), .b_index(b_index),
    .a_hit(a_hit), .a_fwd_data(a_fwd_data), .b_hit(b_hit), .b_fwd_data(b_fwd_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of pending writebacks and the
  // register-file contents that the committed writes produce.
  wb_t               q[$];
  logic [DATA_W-1:0] rf_model [8];
  bit                m_pop, m_push;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      m_pop  = (q.size() != 0) && !drain_stall;
      m_push = in_valid && (q.size() < DEPTH);
      if (m_pop) begin
        rf_model[q[0].idx] = q[0].data;
        void'(q.pop_front());
      end
      if (m_push) q.push_back('{idx: in_index, data: in_data});
    end
  end

  // Log of writes the DUT actually committed, sampled at the edge.
  wb_t wlog[$];
  always @(posedge clk) begin
    if (!reset && rf_we) wlog.push_back('{idx: rf_c_index, data: rf_d_input});
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic              e_we, e_ah, e_bh;
    logic [DATA_W-1:0] e_ad, e_bd, e_d;
    logic [IDX_W-1:0]  e_i;
    e_we = (q.size() != 0) && !drain_stall;
    e_i  = (q.size() != 0) ? q[0].idx  : '0;
    e_d  = (q.size() != 0) ? q[0].data : '0;
    e_ah = 1'b0; e_ad = '0; e_bh = 1'b0; e_bd = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].idx == a_index) begin e_ah = 1'b1; e_ad = q[i].data; end
      if (q[i].idx == b_index) begin e_bh = 1'b1; e_bd = q[i].data; end
    end
    check("count",      count,      q.size());
    check("empty",      empty,      q.size() == 0);
    check("full",       full,       q.size() == DEPTH);
    check("in_ready",   in_ready,   q.size() < DEPTH);
    check("rf_we",      rf_we,      e_we);
    check("rf_c_index", rf_c_index, e_i);
    check("rf_d_input", rf_d_input, e_d);
    check("a_hit",      a_hit,      e_ah);
    check("a_fwd_data", a_fwd_data, e_ad);
    check("b_hit",      b_hit,      e_bh);
    check("b_fwd_data", b_fwd_data, e_bd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
    in_valid = 1'b1;
    in_index = idx;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_log(input int base, input wb_t exp[$]);
    check("log_len", wlog.size(), base + exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < wlog.size()) begin
        check("log_idx",  wlog[base+i].idx,  exp[i].idx);
        check("log_data", wlog[base+i].data, exp[i].data);
      end
    end
  endtask

  initial begin
    wb_t exp[$];
    int  base;

    // Reset, then idle.
    step(); step();
    reset = 1'b0;
    step();
    #1;
    check("idle_empty", empty, 1'b1);
    check("idle_count", count, 3'd0);
    check("idle_we",    rf_we, 1'b0);
    check("idle_ready", in_ready, 1'b1);
    check("idle_a_hit", a_hit, 1'b0);

    // Single push into an empty queue: written in the very next cycle.
    push(3'd3, 16'hBEEF);
    #1;
    check("single_we",  rf_we,      1'b1);
    check("single_idx", rf_c_index, 3'd3);
    check("single_dat", rf_d_input, 16'hBEEF);
    step();
    #1;
    check("single_empty", empty, 1'b1);

    // Fill under stall, refuse a fifth, then drain in order.
    base = wlog.size();
    drain_stall = 1'b1;
    push(3'd0, 16'h0001);
    push(3'd1, 16'h0002);
    push(3'd2, 16'h0003);
    push(3'd3, 16'h0004);
    #1;
    check("fill_full",  full,     1'b1);
    check("fill_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_index = 3'd5; in_data = 16'h0005;
    step();
    #1;
    check("refused_count", count, 3'd4);
    drain_stall = 1'b0;
    step(); step();
    in_valid = 1'b0;
    repeat (4) step();
    exp = '{'{3'd0,16'h0001}, '{3'd1,16'h0002}, '{3'd2,16'h0003},
            '{3'd3,16'h0004}, '{3'd5,16'h0005}};
    check_log(base, exp);

    // Two writes to the same register: forward newest, commit oldest first.
    base = wlog.size();
    drain_stall = 1'b1;
    push(3'd2, 16'h1111);
    push(3'd2, 16'h2222);
    a_index = 3'd2; b_index = 3'd2;
    #1;
    check("dup_a_hit", a_hit,      1'b1);
    check("dup_a_fwd", a_fwd_data, 16'h2222);
    check("dup_b_hit", b_hit,      1'b1);
    check("dup_b_fwd", b_fwd_data, 16'h2222);
    drain_stall = 1'b0;
    step();
    #1;
    check("dup_pop1_hit", a_hit,      1'b1);
    check("dup_pop1_fwd", a_fwd_data, 16'h2222);
    step();
    #1;
    check("dup_pop2_hit", a_hit, 1'b0);
    exp = '{'{3'd2,16'h1111}, '{3'd2,16'h2222}};
    check_log(base, exp);
    check("model_r2", rf_model[2], 16'h2222);

    // Steady stream: one push per cycle, queue never exceeds one entry.
    base = wlog.size();
    exp.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_index = IDX_W'(i % 8);
      in_data  = 16'hA000 + 16'(i);
      exp.push_back('{IDX_W'(i % 8), 16'hA000 + 16'(i)});
      step();
      #1;
      check("stream_count", count, 3'd1);
    end
    in_valid = 1'b0;
    step();
    check_log(base, exp);

    // Lookup miss while 1,2,3 are queued.
    drain_stall = 1'b1;
    push(3'd1, 16'h0101);
    push(3'd2, 16'h0202);
    push(3'd3, 16'h0303);
    a_index = 3'd7;
    #1;
    check("miss_a_hit", a_hit,      1'b0);
    check("miss_a_fwd", a_fwd_data, 16'h0000);
    check("miss_count", count,      3'd3);

    // Mid-stream reset discards the queued entries without any write.
    base = wlog.size();
    reset = 1'b1;
    drain_stall = 1'b0;
    #1;
    check("rst_count", count, 3'd0);
    check("rst_we",    rf_we, 1'b0);
    step();
    reset = 1'b0;
    step(); step();
    check("rst_no_write", wlog.size(), base);
    check("rst_empty",    empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
